// File: rtl/mulxy_seq_if.sv
// Operand/result bundle for the sequential multiplier: the master supplies
// operands and start, the slave returns the product and handshake status.
interface mulxy_seq_if #(
   parameter int X_WIDTH = 4,
   parameter int Y_WIDTH = 4
);
   logic                       start;
   logic                       signed_mode;
   logic [X_WIDTH-1:0]         x;
   logic [Y_WIDTH-1:0]         y;
   logic [X_WIDTH+Y_WIDTH-1:0] p;
   logic                       s;
   logic                       rdy;
   logic                       busy;

   modport master (
      output start, signed_mode, x, y,
      input  p, s, rdy, busy
   );

   modport slave (
      input  start, signed_mode, x, y,
      output p, s, rdy, busy
   );
endinterface

// File: rtl/mulxy_seq.sv
// Shift-and-add multiplier: one multiplier bit per cycle, Y_WIDTH cycles per
// product, sign-magnitude result in signed mode, last result held until replaced.
module mulxy_seq #(
   parameter int X_WIDTH  = 4,
   parameter int Y_WIDTH  = 4,
   parameter int HAS_SIGN = 1
) (
   input logic        clk,
   input logic        reset,
   mulxy_seq_if.slave bus
);
   localparam int P_WIDTH = X_WIDTH + Y_WIDTH;
   localparam int CW      = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nx;
   logic [X_WIDTH-1:0] mx;
   logic [Y_WIDTH-1:0] my;
   logic [P_WIDTH-1:0] acc, acc_nx;
   logic [CW-1:0]      cnt;
   logic               neg;
   logic [P_WIDTH-1:0] p_r;
   logic               s_r, rdy_r;
   logic               sm, load, last;
   logic [X_WIDTH-1:0] x_mag;
   logic [Y_WIDTH-1:0] y_mag;

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      last     = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            load     = 1'b1;
            state_nx = RUN;
         end
         RUN: if (cnt == CW'(Y_WIDTH - 1)) begin
            last     = 1'b1;
            state_nx = DONE;
         end
         DONE: if (bus.start) begin
            load     = 1'b1;
            state_nx = RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The most-negative operand negates to 2^(W-1), which still fits unsigned in W bits.
   always_comb begin
      sm     = (HAS_SIGN != 0) && bus.signed_mode;
      x_mag  = (sm && bus.x[X_WIDTH-1]) ? -bus.x : bus.x;
      y_mag  = (sm && bus.y[Y_WIDTH-1]) ? -bus.y : bus.y;
      acc_nx = my[0] ? acc + (P_WIDTH'(mx) << cnt) : acc;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mx    <= '0;
         my    <= '0;
         acc   <= '0;
         cnt   <= '0;
         neg   <= 1'b0;
         p_r   <= '0;
         s_r   <= 1'b0;
         rdy_r <= 1'b0;
      end else if (load) begin
         mx    <= x_mag;
         my    <= y_mag;
         neg   <= sm && (bus.x[X_WIDTH-1] ^ bus.y[Y_WIDTH-1]);
         acc   <= '0;
         cnt   <= '0;
         rdy_r <= 1'b0;
      end else if (state == RUN) begin
         acc <= acc_nx;
         my  <= my >> 1;
         cnt <= cnt + CW'(1);
         if (last) begin
            p_r   <= acc_nx;
            s_r   <= neg && (acc_nx != '0);
            rdy_r <= 1'b1;
         end
      end
   end

   assign bus.p    = p_r;
   assign bus.s    = (HAS_SIGN != 0) ? s_r : 1'b0;
   assign bus.rdy  = rdy_r;
   assign bus.busy = (state == RUN);
endmodule

// File: tb/tb_mulxy_seq.sv
// Checks a 4x4 signed-capable multiplier and a 2x2 unsigned-only one against
// an arithmetic timing model, plus directed literal results.
module tb_mulxy_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   chk_en = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   mulxy_seq_if #(.X_WIDTH(4), .Y_WIDTH(4)) a_if();
   mulxy_seq_if #(.X_WIDTH(2), .Y_WIDTH(2)) b_if();

   mulxy_seq #(.X_WIDTH(4), .Y_WIDTH(4), .HAS_SIGN(1)) dut_a (
      .clk(clk), .reset(reset), .bus(a_if));
   mulxy_seq #(.X_WIDTH(2), .Y_WIDTH(2), .HAS_SIGN(0)) dut_b (
      .clk(clk), .reset(reset), .bus(b_if));

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic longint prod(input int xw, input int yw, input int xv,
                                   input int yv, input bit sm);
      longint xs = xv;
      longint ys = yv;
      if (sm && xv >= (1 << (xw - 1))) xs = xv - (1 << xw);
      if (sm && yv >= (1 << (yw - 1))) ys = yv - (1 << yw);
      return xs * ys;
   endfunction

   function automatic longint mag(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   // Timing model: a product appears Y_WIDTH edges after acceptance.
   longint ma_p, ma_pend, mb_p, mb_pend;
   bit     ma_s, ma_rdy, ma_busy, mb_s, mb_rdy, mb_busy;
   int     ma_left, mb_left;

   always @(posedge clk) begin
      if (reset) begin
         ma_p <= 0; ma_s <= 0; ma_rdy <= 0; ma_busy <= 0; ma_left <= 0;
      end else if (ma_busy) begin
         ma_left <= ma_left - 1;
         if (ma_left == 1) begin
            ma_busy <= 0;
            ma_rdy  <= 1;
            ma_p    <= mag(ma_pend);
            ma_s    <= (ma_pend < 0);
         end
      end else if (a_if.start) begin
         ma_pend <= prod(4, 4, int'(a_if.x), int'(a_if.y), a_if.signed_mode);
         ma_busy <= 1;
         ma_rdy  <= 0;
         ma_left <= 4;
      end
   end

   always @(posedge clk) begin
      if (reset) begin
         mb_p <= 0; mb_s <= 0; mb_rdy <= 0; mb_busy <= 0; mb_left <= 0;
      end else if (mb_busy) begin
         mb_left <= mb_left - 1;
         if (mb_left == 1) begin
            mb_busy <= 0;
            mb_rdy  <= 1;
            mb_p    <= mag(mb_pend);
            mb_s    <= (mb_pend < 0);
         end
      end else if (b_if.start) begin
         mb_pend <= prod(2, 2, int'(b_if.x), int'(b_if.y), 1'b0);
         mb_busy <= 1;
         mb_rdy  <= 0;
         mb_left <= 2;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("A.p", longint'(a_if.p), ma_p);
         chk("A.s", longint'(a_if.s), longint'(ma_s));
         chk("A.rdy", longint'(a_if.rdy), longint'(ma_rdy));
         chk("A.busy", longint'(a_if.busy), longint'(ma_busy));
         chk("B.p", longint'(b_if.p), mb_p);
         chk("B.s", longint'(b_if.s), longint'(mb_s));
         chk("B.rdy", longint'(b_if.rdy), longint'(mb_rdy));
         chk("B.busy", longint'(b_if.busy), longint'(mb_busy));
      end
   end

   task automatic op_a(input logic [3:0] xv, input logic [3:0] yv, input bit sm,
                       input int ep, input bit es, input bit noisy, input string nm);
      int n = 0;
      @(negedge clk);
      a_if.start = 1'b1; a_if.x = xv; a_if.y = yv; a_if.signed_mode = sm;
      @(negedge clk);
      a_if.start = 1'b0;
      while (!a_if.rdy && n < 20) begin
         if (noisy) begin
            a_if.start = 1'($urandom);
            a_if.x = 4'($urandom);
            a_if.y = 4'($urandom);
            a_if.signed_mode = 1'($urandom);
         end
         @(negedge clk);
         n++;
      end
      a_if.start = 1'b0;
      chk({nm, ".lat"}, n, 4);
      chk({nm, ".p"}, longint'(a_if.p), ep);
      chk({nm, ".s"}, longint'(a_if.s), longint'(es));
      chk({nm, ".model_p"}, ma_p, ep);
   endtask

   task automatic op_b(input logic [1:0] xv, input logic [1:0] yv, input int ep);
      int n = 0;
      @(negedge clk);
      b_if.start = 1'b1; b_if.x = xv; b_if.y = yv; b_if.signed_mode = 1'($urandom);
      @(negedge clk);
      b_if.start = 1'b0;
      while (!b_if.rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("B.lat", n, 2);
      chk("B.pair_p", longint'(b_if.p), ep);
      chk("B.pair_s", longint'(b_if.s), 0);
   endtask

   initial begin
      int last, pulses;
      a_if.start = 0; a_if.x = 0; a_if.y = 0; a_if.signed_mode = 0;
      b_if.start = 0; b_if.x = 0; b_if.y = 0; b_if.signed_mode = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      chk("rst.p", longint'(a_if.p), 0);
      chk("rst.rdy", longint'(a_if.rdy), 0);
      chk("rst.busy", longint'(a_if.busy), 0);
      reset = 1'b0;

      op_a(4'd15, 4'd15, 0, 225, 0, 0, "u15x15");
      repeat (10) @(negedge clk);
      chk("hold.p", longint'(a_if.p), 225);
      op_a(4'hD, 4'd5, 1, 15, 1, 0, "s_m3x5");
      op_a(4'h8, 4'h8, 1, 64, 0, 0, "s_m8xm8");
      op_a(4'h0, 4'hB, 1, 0, 0, 0, "s_0xm5");
      op_a(4'hD, 4'd5, 0, 65, 0, 1, "u13x5_noisy");
      op_a(4'd9, 4'd11, 0, 99, 0, 1, "u9x11_noisy");

      // abort in the second RUN cycle
      @(negedge clk);
      a_if.start = 1'b1; a_if.x = 4'd3; a_if.y = 4'd3; a_if.signed_mode = 0;
      @(negedge clk);
      a_if.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort.p", longint'(a_if.p), 0);
      chk("abort.s", longint'(a_if.s), 0);
      chk("abort.rdy", longint'(a_if.rdy), 0);
      chk("abort.busy", longint'(a_if.busy), 0);
      reset = 1'b0;
      op_a(4'd6, 4'd7, 0, 42, 0, 0, "u6x7");

      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 60) == 0);
         a_if.start = ($urandom_range(0, 2) == 0);
         a_if.x = 4'($urandom);
         a_if.y = 4'($urandom);
         a_if.signed_mode = 1'($urandom);
      end
      @(negedge clk);
      reset = 1'b0;
      a_if.start = 1'b0;
      repeat (6) @(negedge clk);

      for (int xi = 0; xi < 4; xi++)
         for (int yi = 0; yi < 4; yi++)
            op_b(2'(xi), 2'(yi), xi * yi);

      last = -1;
      pulses = 0;
      @(negedge clk);
      b_if.start = 1'b1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         b_if.x = 2'($urandom);
         b_if.y = 2'($urandom);
         if (b_if.rdy) begin
            if (last >= 0) chk("B.rdy_period", c - last, 3);
            last = c;
            pulses++;
         end
      end
      b_if.start = 1'b0;
      chk("B.pulses", pulses, 10);
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
